// File: rtl/axil_ram_slave.sv
// AXI4-Lite slave RAM: word-organised memory with byte-strobe writes and
// independent read/write FSMs that insert WAIT_CYCLES wait states per access.
module axil_ram_slave #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] AWdata,
    input  logic        AWvalid,
    output logic        AWready,
    input  logic [2:0]  AWprot,
    input  logic [31:0] Wdata,
    input  logic [3:0]  Wstrb,
    input  logic        Wvalid,
    output logic        Wready,
    output logic        Bvalid,
    input  logic        Bready,
    input  logic [31:0] ARdata,
    input  logic        ARvalid,
    output logic        ARready,
    input  logic [2:0]  ARprot,
    output logic [31:0] Rdata,
    output logic        Rvalid,
    input  logic        RReady
);
    localparam int         DEPTH     = 1 << ADDR_BITS;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [2:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_WAIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

    logic [31:0] mem [DEPTH];

    w_state_t             w_state_q, w_state_d;
    logic [3:0]           w_cnt_q, w_cnt_d;
    logic [ADDR_BITS-1:0] w_idx_q, w_idx_d;
    logic [31:0]          w_data_q, w_data_d;
    logic [3:0]           w_strb_q, w_strb_d;
    logic                 w_commit;

    r_state_t             r_state_q, r_state_d;
    logic [3:0]           r_cnt_q, r_cnt_d;
    logic [ADDR_BITS-1:0] r_idx_q, r_idx_d;
    logic [31:0]          rdata_q, rdata_d;

    // Protection bits and the sub-word / aliased address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{AWprot, ARprot, AWdata[31:ADDR_BITS+2], AWdata[1:0],
                           ARdata[31:ADDR_BITS+2], ARdata[1:0]};

    assign AWready = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_D);
    assign Wready  = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_A);
    assign Bvalid  = (w_state_q == W_RESP);
    assign ARready = (r_state_q == R_IDLE);
    assign Rvalid  = (r_state_q == R_DATA);
    assign Rdata   = rdata_q;

    always_comb begin
        w_state_d = w_state_q;
        w_cnt_d   = w_cnt_q;
        w_idx_d   = w_idx_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        w_commit  = 1'b0;
        if (AWvalid && AWready) begin
            w_idx_d = AWdata[ADDR_BITS+1:2];
        end
        if (Wvalid && Wready) begin
            w_data_d = Wdata;
            w_strb_d = Wstrb;
        end
        case (w_state_q)
            W_IDLE: begin
                if (AWvalid && Wvalid) begin
                    w_state_d = W_WAIT;
                    w_cnt_d   = WAIT_INIT;
                end else if (AWvalid) begin
                    w_state_d = W_HAVE_A;
                end else if (Wvalid) begin
                    w_state_d = W_HAVE_D;
                end
            end
            W_HAVE_A: begin
                if (Wvalid) begin
                    w_state_d = W_WAIT;
                    w_cnt_d   = WAIT_INIT;
                end
            end
            W_HAVE_D: begin
                if (AWvalid) begin
                    w_state_d = W_WAIT;
                    w_cnt_d   = WAIT_INIT;
                end
            end
            W_WAIT: begin
                if (w_cnt_q == 4'd0) begin
                    w_commit  = 1'b1;
                    w_state_d = W_RESP;
                end else begin
                    w_cnt_d = w_cnt_q - 4'd1;
                end
            end
            W_RESP: begin
                if (Bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        r_idx_d   = r_idx_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (ARvalid) begin
                    r_idx_d   = ARdata[ADDR_BITS+1:2];
                    r_cnt_d   = WAIT_INIT;
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                // Sampled before this edge's write lands, giving read-before-write.
                if (r_cnt_q == 4'd0) begin
                    rdata_d   = mem[r_idx_q];
                    r_state_d = R_DATA;
                end else begin
                    r_cnt_d = r_cnt_q - 4'd1;
                end
            end
            R_DATA: begin
                if (RReady) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state_q <= W_IDLE;
            w_cnt_q   <= 4'd0;
            w_idx_q   <= '0;
            w_data_q  <= 32'd0;
            w_strb_q  <= 4'd0;
            r_state_q <= R_IDLE;
            r_cnt_q   <= 4'd0;
            r_idx_q   <= '0;
            rdata_q   <= 32'd0;
        end else begin
            w_state_q <= w_state_d;
            w_cnt_q   <= w_cnt_d;
            w_idx_q   <= w_idx_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            r_idx_q   <= r_idx_d;
            rdata_q   <= rdata_d;
        end
    end

    // Memory contents deliberately survive reset; w_commit is already gated by reset state.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb_q[b]) begin
                    mem[w_idx_q][8*b +: 8] <= w_data_q[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_axil_ram_slave.sv
// Testbench for axil_ram_slave: two instances (WAIT_CYCLES 0 and 3) driven by
// directed and randomized transactions, checked against a word-array model.
module tb_axil_ram_slave;
    localparam int AB   = 10;
    localparam int NDUT = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] aw_addr  [NDUT];
    logic        aw_valid [NDUT];
    logic        aw_ready [NDUT];
    logic [31:0] w_data   [NDUT];
    logic [3:0]  w_strb   [NDUT];
    logic        w_valid  [NDUT];
    logic        w_ready  [NDUT];
    logic        b_valid  [NDUT];
    logic        b_ready  [NDUT];
    logic [31:0] ar_addr  [NDUT];
    logic        ar_valid [NDUT];
    logic        ar_ready [NDUT];
    logic [31:0] r_data   [NDUT];
    logic        r_valid  [NDUT];
    logic        r_ready  [NDUT];

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] ref_mem [NDUT][1 << AB];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        axil_ram_slave #(.ADDR_BITS(AB), .WAIT_CYCLES(gi * 3)) u_dut (
            .clk     (clk),
            .rstn    (rstn),
            .AWdata  (aw_addr[gi]),
            .AWvalid (aw_valid[gi]),
            .AWready (aw_ready[gi]),
            .AWprot  (3'b000),
            .Wdata   (w_data[gi]),
            .Wstrb   (w_strb[gi]),
            .Wvalid  (w_valid[gi]),
            .Wready  (w_ready[gi]),
            .Bvalid  (b_valid[gi]),
            .Bready  (b_ready[gi]),
            .ARdata  (ar_addr[gi]),
            .ARvalid (ar_valid[gi]),
            .ARready (ar_ready[gi]),
            .ARprot  (3'b000),
            .Rdata   (r_data[gi]),
            .Rvalid  (r_valid[gi]),
            .RReady  (r_ready[gi])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % (1 << AB));
    endfunction

    function automatic int wait_of(input int d);
        return d * 3;
    endfunction

    function automatic void model_write(input int d, input logic [31:0] a,
                                        input logic [31:0] data, input logic [3:0] s);
        int i;
        i = widx(a);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) ref_mem[d][i][8*b +: 8] = data[8*b +: 8];
        end
    endfunction

    function automatic logic [31:0] mkaddr(input int idx);
        logic [31:0] a;
        a = ($urandom_range(0, 15) << (AB + 2)) + (idx * 4) + $urandom_range(0, 3);
        return a;
    endfunction

    // Entered just after the last request handshake edge; ends just after the B handshake.
    task automatic wait_bresp(input int d, input int bdelay);
        int lat;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!b_valid[d] && lat < 40);
        check($sformatf("d%0d_write_latency", d), lat, 1 + wait_of(d));
        for (int j = 0; j < bdelay; j++) begin
            check("bvalid_hold", b_valid[d], 1'b1);
            check("awready_in_resp", aw_ready[d], 1'b0);
            check("wready_in_resp", w_ready[d], 1'b0);
            @(negedge clk);
        end
        b_ready[d] = 1'b1;
        @(posedge clk);
        #1 b_ready[d] = 1'b0;
    endtask

    task automatic do_write(input int d, input logic [31:0] a, input logic [31:0] data,
                            input logic [3:0] s, input int bdelay);
        bit aw_done, wd_done, awr, wr;
        int guard;
        aw_done = 0; wd_done = 0; guard = 0;
        aw_addr[d] = a; aw_valid[d] = 1'b1;
        w_data[d] = data; w_strb[d] = s; w_valid[d] = 1'b1;
        while (!(aw_done && wd_done) && guard < 50) begin
            @(negedge clk);
            awr = aw_ready[d];
            wr  = w_ready[d];
            @(posedge clk);
            if (aw_valid[d] && awr) aw_done = 1;
            if (w_valid[d] && wr) wd_done = 1;
            #1;
            if (aw_done) aw_valid[d] = 1'b0;
            if (wd_done) w_valid[d] = 1'b0;
            guard++;
        end
        aw_valid[d] = 1'b0;
        w_valid[d]  = 1'b0;
        check("write_handshake", {31'd0, aw_done && wd_done}, 32'd1);
        wait_bresp(d, bdelay);
        model_write(d, a, data, s);
        $display("write d%0d addr=0x%08h data=0x%08h strb=%b bdelay=%0d", d, a, data, s, bdelay);
    endtask

    task automatic do_read(input int d, input logic [31:0] a, input logic [31:0] exp,
                           input int rdelay);
        bit done, arr;
        int guard, lat;
        done = 0; guard = 0; lat = 0;
        ar_addr[d] = a; ar_valid[d] = 1'b1;
        while (!done && guard < 50) begin
            @(negedge clk);
            arr = ar_ready[d];
            @(posedge clk);
            if (arr) done = 1;
            #1;
            if (done) ar_valid[d] = 1'b0;
            guard++;
        end
        ar_valid[d] = 1'b0;
        check("read_handshake", {31'd0, done}, 32'd1);
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!r_valid[d] && lat < 40);
        check($sformatf("d%0d_read_latency", d), lat, 1 + wait_of(d));
        check($sformatf("d%0d_rdata@%08h", d, a), r_data[d], exp);
        for (int j = 0; j < rdelay; j++) begin
            check("rvalid_hold", r_valid[d], 1'b1);
            check("rdata_hold", r_data[d], exp);
            check("arready_in_data", ar_ready[d], 1'b0);
            @(negedge clk);
        end
        r_ready[d] = 1'b1;
        @(posedge clk);
        #1 r_ready[d] = 1'b0;
        $display("read  d%0d addr=0x%08h exp=0x%08h rdelay=%0d", d, a, exp, rdelay);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int idxs [8];
        rstn = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            aw_addr[d] = 32'd0; aw_valid[d] = 1'b1;
            w_data[d] = 32'd0; w_strb[d] = 4'hF; w_valid[d] = 1'b1;
            ar_addr[d] = 32'd0; ar_valid[d] = 1'b1;
            b_ready[d] = 1'b0; r_ready[d] = 1'b0;
        end

        // Reset with all valids high
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check("rst_awready", aw_ready[d], 1'b1);
            check("rst_wready", w_ready[d], 1'b1);
            check("rst_arready", ar_ready[d], 1'b1);
            check("rst_bvalid", b_valid[d], 1'b0);
            check("rst_rvalid", r_valid[d], 1'b0);
            check("rst_rdata", r_data[d], 32'd0);
            aw_valid[d] = 1'b0; w_valid[d] = 1'b0; ar_valid[d] = 1'b0;
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Full write, read back, partial write, aliasing, null strobe (no wait states)
        do_write(0, 32'h100, 32'hDEADBEEF, 4'b1111, 0);
        do_read(0, 32'h100, 32'hDEADBEEF, 0);
        do_write(0, 32'h100, 32'h0000AA00, 4'b0010, 1);
        do_read(0, 32'h100, 32'hDEADAAEF, 0);
        do_read(0, 32'h103, 32'hDEADAAEF, 0);
        do_read(0, 32'h100 | (32'd1 << (AB + 2)), 32'hDEADAAEF, 0);
        do_write(0, 32'h100, 32'hFFFFFFFF, 4'b0000, 0);
        do_read(0, 32'h100, 32'hDEADAAEF, 0);

        // Same-edge commit and Rdata load to one word
        do_write(0, 32'h200, 32'h11111111, 4'b1111, 0);
        fork
            do_write(0, 32'h200, 32'h22222222, 4'b1111, 0);
            do_read(0, 32'h200, 32'h11111111, 0);
        join
        do_read(0, 32'h200, 32'h22222222, 0);

        // Read backpressure with wait states
        do_write(1, 32'h300, 32'hCAFEF00D, 4'b1111, 0);
        do_read(1, 32'h300, 32'hCAFEF00D, 5);

        // Split handshake: W offered three cycles ahead of AW
        w_data[1] = 32'h12345678; w_strb[1] = 4'hF; w_valid[1] = 1'b1;
        @(posedge clk);
        #1 w_valid[1] = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("split_wready", w_ready[1], 1'b0);
            check("split_awready", aw_ready[1], 1'b1);
            check("split_bvalid", b_valid[1], 1'b0);
            if (j < 2) @(posedge clk);
        end
        aw_addr[1] = 32'h304; aw_valid[1] = 1'b1;
        @(posedge clk);
        #1 aw_valid[1] = 1'b0;
        wait_bresp(1, 5);
        model_write(1, 32'h304, 32'h12345678, 4'hF);
        $display("write d1 addr=0x00000304 data=0x12345678 strb=1111 split");
        do_read(1, 32'h304, 32'h12345678, 0);

        // Reset while a read sits in its wait states
        ar_addr[1] = 32'h300; ar_valid[1] = 1'b1;
        @(posedge clk);
        #1 ar_valid[1] = 1'b0;
        @(negedge clk);
        check("rwait_arready", ar_ready[1], 1'b0);
        #2 rstn = 1'b0;
        #1;
        check("midrst_arready", ar_ready[1], 1'b1);
        check("midrst_rvalid", r_valid[1], 1'b0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check("postrst_rvalid", r_valid[1], 1'b0);
            check("postrst_rdata", r_data[1], 32'd0);
        end
        @(posedge clk);
        #1;
        do_read(1, 32'h300, 32'hCAFEF00D, 0);
        do_read(0, 32'h100, 32'hDEADAAEF, 0);

        // Randomized traffic on both instances against the model
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < 8; i++) begin
                idxs[i] = int'($urandom_range(0, (1 << AB) - 1));
                do_write(d, mkaddr(idxs[i]), $urandom, 4'hF, 0);
            end
            for (int n = 0; n < 30; n++) begin
                int k;
                logic [31:0] a;
                k = int'($urandom_range(0, 7));
                a = mkaddr(idxs[k]);
                if ($urandom_range(0, 1) == 1)
                    do_write(d, a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
                else
                    do_read(d, a, ref_mem[d][widx(a)], int'($urandom_range(0, 3)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
